// File: rtl/shift_register_n.sv
// Universal shift/rotate register: parallel load, clear, and multi-cycle
// shift/rotate by a programmable amount (one bit per clock) with carry capture.
module shift_register_n #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] D,
    input  logic             serial_in,
    output logic [WIDTH-1:0] Q,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SAR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_RCL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       step_op;
    logic [WIDTH-1:0] step_q;
    logic             step_c;
    logic [AMT_W-1:0] amt_sat;

    // One single-bit step; result is {carry, Q}
    function automatic logic [WIDTH:0] step_f(input logic [2:0]       o,
                                              input logic [WIDTH-1:0] q,
                                              input logic             c,
                                              input logic             si);
        logic [WIDTH:0] r;
        case (o)
            OP_SHL:  r = {q, si};
            OP_SHR:  r = {q[0], si, q[WIDTH-1:1]};
            OP_SAR:  r = {q[0], q[WIDTH-1], q[WIDTH-1:1]};
            OP_ROL:  r = {q, q[WIDTH-1]};
            OP_ROR:  r = {q[0], q[0], q[WIDTH-1:1]};
            OP_RCL:  r = {q, c};
            default: r = {c, q};
        endcase
        return r;
    endfunction

    always_comb begin
        step_op           = (state_q == ST_SHIFT) ? op_q : op;
        {step_c, step_q}  = step_f(step_op, q_q, carry_q, serial_in);
        amt_sat           = (amt > AMT_MAX) ? AMT_MAX : amt;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;
        q_d     = q_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start) begin
                op_d = op;
                case (op)
                    OP_LOAD: begin
                        q_d    = D;
                        done_d = 1'b1;
                    end
                    OP_CLR: begin
                        q_d     = '0;
                        carry_d = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: begin
                        if (amt == '0) begin
                            done_d = 1'b1;
                        end else begin
                            q_d     = step_q;
                            carry_d = step_c;
                            rem_d   = amt_sat - AMT_ONE;
                            if (amt_sat == AMT_ONE) begin
                                done_d = 1'b1;
                            end else begin
                                busy_d  = 1'b1;
                                state_d = ST_SHIFT;
                            end
                        end
                    end
                endcase
            end
        end else begin
            q_d     = step_q;
            carry_d = step_c;
            rem_d   = rem_q - AMT_ONE;
            if (rem_q == AMT_ONE) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            op_q    <= OP_LOAD;
            q_q     <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            q_q     <= q_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q     = q_q;
    assign carry = carry_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
